uart_tx_arbiter: RTL

//  Round-robin arbiter that shares one uart_top transmitter among NUM_REQ byte sources.

---
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte sources share one UART transmitter.
// One frame is in flight at a time: launch, wait for the transmitter to go busy,
// then wait for it to finish. A transmitter that never starts raises err.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 8,
  parameter int START_TIMEOUT = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        uart_send,
  output logic [DATA_W-1:0]           uart_data,
  input  logic                        uart_busy,
  output logic [$clog2(NUM_REQ)-1:0]  active_id,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_t;

  state_t            state;
  logic [ID_W-1:0]   last;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   winner;

  // First pending requester after the last one served, wrapping around.
  function automatic logic [ID_W-1:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                  input logic [ID_W-1:0]    prev);
    logic [ID_W-1:0] w;
    logic            hit;
    int              idx;
    w   = '0;
    hit = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(prev) + i) % NUM_REQ;
      if (!hit && r[idx]) begin
        w   = ID_W'(idx);
        hit = 1'b1;
      end
    end
    return w;
  endfunction

  // Combinational round-robin choice; only consumed while IDLE.
  always_comb begin
    winner = pick_winner(req, last);
  end

  // Frame sequencer with registered outputs; grant/send/done/err are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= ID_W'(NUM_REQ - 1);
      cnt       <= '0;
      grant     <= '0;
      uart_send <= 1'b0;
      uart_data <= '0;
      active_id <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      grant     <= '0;
      uart_send <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= LAUNCH;
            grant     <= NUM_REQ'(1) << winner;
            uart_send <= 1'b1;
            uart_data <= req_data[int'(winner)*DATA_W +: DATA_W];
            active_id <= winner;
            last      <= winner;
            busy      <= 1'b1;
          end
        end
        LAUNCH: begin
          state <= WAIT_START;
          cnt   <= '0;
        end
        WAIT_START: begin
          if (uart_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
            // Byte is dropped; last keeps the failed owner so someone else goes next.
            state <= IDLE;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!uart_busy) begin
            state <= IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
